// File: rtl/uart_block_tx_sched_if.sv
// Handshake bundle between the two block requesters, the byte scheduler and the UART transmitter.
interface uart_block_tx_sched_if;
  logic         req0;
  logic [127:0] data0;
  logic         ack0;
  logic         req1;
  logic [127:0] data1;
  logic         ack1;
  logic         flush;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic         tx_ready;
  logic         busy;
  logic         owner;
  logic         done;

  modport master (
    output req0, data0, req1, data1, flush, tx_ready,
    input  ack0, ack1, tx_valid, tx_data, busy, owner, done
  );

  modport slave (
    input  req0, data0, req1, data1, flush, tx_ready,
    output ack0, ack1, tx_valid, tx_data, busy, owner, done
  );
endinterface

// File: rtl/uart_block_tx_sched.sv
// Round-robin scheduler of two 128-bit result blocks onto the UART byte channel,
// optional source header byte, MSB byte first, all outputs registered.
module uart_block_tx_sched #(
  parameter int BLOCK_BYTES = 16,
  parameter int HDR_EN      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_block_tx_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(BLOCK_BYTES - 1);
  localparam bit         USE_HDR  = (HDR_EN != 0);

  state_t         state_r, state_s;
  logic [127:0]   shift_r, shift_s;
  logic [4:0]     count_r, count_s;
  logic           last_grant_r, last_grant_s;
  logic           owner_r, owner_s;
  logic           busy_r, busy_s;
  logic           tx_valid_r, tx_valid_s;
  logic [7:0]     tx_data_r, tx_data_s;
  logic           ack0_r, ack0_s;
  logic           ack1_r, ack1_s;
  logic           done_r, done_s;

  logic           any_req_s;
  logic           src_s;
  logic [127:0]   grant_data_s;
  logic           xfer_s;
  logic           last_byte_s;

  // Arbitration and transfer qualifiers
  always_comb begin
    any_req_s = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      src_s = ~last_grant_r;
    end else if (bus.req1) begin
      src_s = 1'b1;
    end else begin
      src_s = 1'b0;
    end
    grant_data_s = src_s ? bus.data1 : bus.data0;
    xfer_s       = tx_valid_r & bus.tx_ready;
    last_byte_s  = (count_r == LAST_IDX);
  end

  // Next-state and next registered-output logic
  always_comb begin
    state_s      = state_r;
    shift_s      = shift_r;
    count_s      = count_r;
    last_grant_s = last_grant_r;
    owner_s      = owner_r;
    busy_s       = busy_r;
    tx_valid_s   = tx_valid_r;
    tx_data_s    = tx_data_r;
    ack0_s       = 1'b0;
    ack1_s       = 1'b0;
    done_s       = 1'b0;

    if (bus.flush) begin
      // A byte accepted on this edge is already gone; the rest of the block is dropped.
      state_s    = IDLE;
      tx_valid_s = 1'b0;
      busy_s     = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            shift_s      = grant_data_s;
            owner_s      = src_s;
            last_grant_s = src_s;
            ack0_s       = ~src_s;
            ack1_s       = src_s;
            busy_s       = 1'b1;
            count_s      = 5'd0;
            tx_valid_s   = 1'b1;
            if (USE_HDR) begin
              state_s   = HDR;
              tx_data_s = 8'hA0 | {7'd0, src_s};
            end else begin
              state_s   = SEND;
              tx_data_s = grant_data_s[127:120];
            end
          end else begin
            state_s = IDLE;
          end
        end
        HDR: begin
          if (xfer_s) begin
            state_s   = SEND;
            tx_data_s = shift_r[127:120];
          end else begin
            state_s = HDR;
          end
        end
        SEND: begin
          if (xfer_s) begin
            shift_s = {shift_r[119:0], 8'h00};
            count_s = count_r + 5'd1;
            if (last_byte_s) begin
              state_s    = IDLE;
              tx_valid_s = 1'b0;
              busy_s     = 1'b0;
              done_s     = 1'b1;
            end else begin
              state_s   = SEND;
              tx_data_s = shift_r[119:112];
            end
          end else begin
            state_s = SEND;
          end
        end
        default: begin
          state_s    = IDLE;
          tx_valid_s = 1'b0;
          busy_s     = 1'b0;
        end
      endcase
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      shift_r      <= 128'd0;
      count_r      <= 5'd0;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      busy_r       <= 1'b0;
      tx_valid_r   <= 1'b0;
      tx_data_r    <= 8'h00;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      shift_r      <= shift_s;
      count_r      <= count_s;
      last_grant_r <= last_grant_s;
      owner_r      <= owner_s;
      busy_r       <= busy_s;
      tx_valid_r   <= tx_valid_s;
      tx_data_r    <= tx_data_s;
      ack0_r       <= ack0_s;
      ack1_r       <= ack1_s;
      done_r       <= done_s;
    end
  end

  assign bus.ack0     = ack0_r;
  assign bus.ack1     = ack1_r;
  assign bus.tx_valid = tx_valid_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.busy     = busy_r;
  assign bus.owner    = owner_r;
  assign bus.done     = done_r;

  uart_block_tx_sched_chk u_chk (
    .clk      (clk),
    .reset    (reset),
    .ack0     (ack0_r),
    .ack1     (ack1_r),
    .busy     (busy_r),
    .done     (done_r),
    .tx_valid (tx_valid_r),
    .tx_data  (tx_data_r),
    .tx_ready (bus.tx_ready),
    .flush    (bus.flush)
  );

endmodule

// Protocol invariants of the scheduler outputs; no logic, observation only.
module uart_block_tx_sched_chk (
  input logic       clk,
  input logic       reset,
  input logic       ack0,
  input logic       ack1,
  input logic       busy,
  input logic       done,
  input logic       tx_valid,
  input logic [7:0] tx_data,
  input logic       tx_ready,
  input logic       flush
);

  a_single_ack: assert property (@(posedge clk) disable iff (reset) !(ack0 && ack1));

  a_done_idle: assert property (@(posedge clk) disable iff (reset) done |-> !busy && !tx_valid);

  a_hold: assert property (@(posedge clk) disable iff (reset)
    (tx_valid && !tx_ready && !flush) |=> (tx_valid && $stable(tx_data)));

endmodule
